// File: rtl/harmonic_note_player_pkg.sv
// Shared constants, FSM encoding and table helpers for the harmonic note player.
// The waveform is a parabolic half-wave approximation of a sine over a 2^PHASE_W period.
package harmonic_note_player_pkg;

   localparam int WEIGHT_W      = 4;
   localparam int STEP_W        = 20;
   localparam int PHASE_W       = 20;
   localparam int WAVE_W        = 16;
   localparam int STEP_PER_NOTE = 5461;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PLAYING = 1'b1
   } player_state_e;

   // Frequency table entry: phase step per sample request for a note index.
   function automatic logic [STEP_W-1:0] note_step(input logic [31:0] note);
      logic [31:0] prod;
      prod = note * 32'(STEP_PER_NOTE);
      return prod[STEP_W-1:0];
   endfunction

   function automatic logic signed [WAVE_W-1:0] wave_lookup(input logic [PHASE_W-1:0] phase);
      logic [17:0] x;
      logic [17:0] prod;
      logic [16:0] mag;
      logic [15:0] mag_sat;
      x       = 18'(phase[PHASE_W-2 -: 9]);
      prod    = x * (18'd512 - x);
      mag     = prod[17:1];
      // The crest value 32768 does not fit the positive range.
      mag_sat = (mag[16] | mag[15]) ? 16'h7FFF : mag[15:0];
      return phase[PHASE_W-1] ? -$signed(mag_sat) : $signed(mag_sat);
   endfunction

endpackage

// File: rtl/harmonic_note_player_sine_reader.sv
// Per-harmonic phase accumulator plus waveform lookup.
// A request advances the phase; the sample at the new phase is ready two cycles later.
module harmonic_note_player_sine_reader
   import harmonic_note_player_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_i,
   input  logic [STEP_W-1:0]        step_i,
   output logic signed [WAVE_W-1:0] sample_o,
   output logic                     ready_o
);

   logic [PHASE_W-1:0]       phase_q;
   logic [PHASE_W-1:0]       phase_d;
   logic                     pend_q;
   logic                     ready_q;
   logic signed [WAVE_W-1:0] sample_q;

   assign phase_d = phase_q + PHASE_W'(step_i);

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q  <= '0;
         pend_q   <= 1'b0;
         ready_q  <= 1'b0;
         sample_q <= '0;
      end else begin
         pend_q  <= req_i;
         ready_q <= pend_q;
         if (req_i) begin
            phase_q <= phase_d;
         end
         if (pend_q) begin
            sample_q <= wave_lookup(phase_q);
         end
      end
   end

   assign sample_o = sample_q;
   assign ready_o  = ready_q;

endmodule

// File: rtl/harmonic_note_player.sv
// Note sequencer with beat-counted duration and a weighted sum of NUM_HARMONICS waveform readers.
// SAMPLE_W is expected to be at least WAVE_W (16).
module harmonic_note_player
   import harmonic_note_player_pkg::*;
#(
   parameter int NUM_HARMONICS = 3,
   parameter int NOTE_W        = 6,
   parameter int DUR_W         = 6,
   parameter int SAMPLE_W      = 16
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                play_enable,
   input  logic [NOTE_W-1:0]                   note_to_load,
   input  logic [DUR_W-1:0]                    duration_to_load,
   input  logic                                load_new_note,
   input  logic [WEIGHT_W*NUM_HARMONICS-1:0]   weights,
   input  logic                                beat,
   input  logic                                generate_next_sample,
   output logic                                done_with_note,
   output logic                                busy,
   output logic signed [SAMPLE_W-1:0]          sample_out,
   output logic                                new_sample_ready
);

   localparam int MIX_W     = SAMPLE_W + 6;
   localparam int ROM_DEPTH = 1 << NOTE_W;

   player_state_e                     state_q;
   logic [DUR_W-1:0]                  cnt_q;
   logic [NOTE_W-1:0]                 note_q;
   logic [WEIGHT_W*NUM_HARMONICS-1:0] weights_q;
   logic                              done_q;
   logic                              beat_en;

   assign beat_en = beat && play_enable && (state_q == ST_PLAYING);

   // A load in the same cycle as a beat wins: the beat is simply dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         note_q    <= '0;
         weights_q <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (load_new_note) begin
            state_q   <= ST_PLAYING;
            cnt_q     <= duration_to_load;
            note_q    <= note_to_load;
            weights_q <= weights;
         end else if (beat_en) begin
            if (cnt_q <= DUR_W'(1)) begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
            end else begin
               cnt_q <= cnt_q - DUR_W'(1);
            end
         end
      end
   end

   assign busy           = (state_q == ST_PLAYING);
   assign done_with_note = done_q;

   // Frequency table, read through a register so it can map to block RAM.
   logic [STEP_W-1:0] freq_rom [ROM_DEPTH];
   logic [STEP_W-1:0] base_step_q;

   for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
      assign freq_rom[gi] = note_step(32'(gi));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_step_q <= '0;
      end else begin
         base_step_q <= freq_rom[note_q];
      end
   end

   logic                     rd_req;
   logic                     idle_req;
   logic [NUM_HARMONICS-1:0] rd_ready;
   logic                     all_ready;

   assign rd_req    = generate_next_sample && play_enable && busy;
   assign idle_req  = generate_next_sample && play_enable && !busy;
   assign all_ready = &rd_ready;

   logic [STEP_W-1:0]        hstep    [NUM_HARMONICS];
   logic signed [WAVE_W-1:0] rd_sample[NUM_HARMONICS];
   logic signed [MIX_W-1:0]  samp_ext [NUM_HARMONICS];
   logic signed [MIX_W-1:0]  wgt_ext  [NUM_HARMONICS];
   logic signed [MIX_W-1:0]  prod     [NUM_HARMONICS];
   logic signed [MIX_W-1:0]  term     [NUM_HARMONICS];

   for (genvar gi = 0; gi < NUM_HARMONICS; gi++) begin : g_harm
      assign hstep[gi] = base_step_q * STEP_W'(gi + 1);

      harmonic_note_player_sine_reader u_reader (
         .clk      (clk),
         .reset    (reset),
         .req_i    (rd_req),
         .step_i   (hstep[gi]),
         .sample_o (rd_sample[gi]),
         .ready_o  (rd_ready[gi])
      );

      assign samp_ext[gi] = {{(MIX_W-WAVE_W){rd_sample[gi][WAVE_W-1]}}, rd_sample[gi]};
      assign wgt_ext[gi]  = {{(MIX_W-WEIGHT_W){1'b0}}, weights_q[gi*WEIGHT_W +: WEIGHT_W]};
      assign prod[gi]     = samp_ext[gi] * wgt_ext[gi];
      assign term[gi]     = prod[gi] >>> 4;
   end

   logic signed [MIX_W-1:0]    mix_sum;
   logic signed [SAMPLE_W-1:0] mix_sat;

   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < NUM_HARMONICS; i++) begin
         mix_sum = mix_sum + term[i];
      end
   end

   // Any disagreement among the bits above the sample's sign bit means overflow.
   always_comb begin
      mix_sat = mix_sum[SAMPLE_W-1:0];
      if (!mix_sum[MIX_W-1] && (|mix_sum[MIX_W-2:SAMPLE_W-1])) begin
         mix_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
      end else if (mix_sum[MIX_W-1] && !(&mix_sum[MIX_W-2:SAMPLE_W-1])) begin
         mix_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
      end
   end

   // Idle requests and the rest flag travel alongside the readers' two-cycle latency.
   logic [1:0]                 idle_pipe_q;
   logic [1:0]                 mute_pipe_q;
   logic                       mute_d;
   logic signed [SAMPLE_W-1:0] sample_q;
   logic                       ready_q;

   assign mute_d = (note_q == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_pipe_q <= '0;
         mute_pipe_q <= '0;
         sample_q    <= '0;
         ready_q     <= 1'b0;
      end else begin
         idle_pipe_q <= {idle_pipe_q[0], idle_req};
         mute_pipe_q <= {mute_pipe_q[0], mute_d};
         ready_q     <= all_ready | idle_pipe_q[1];
         if (all_ready) begin
            sample_q <= mute_pipe_q[1] ? '0 : mix_sat;
         end else if (idle_pipe_q[1]) begin
            sample_q <= '0;
         end
      end
   end

   assign sample_out       = sample_q;
   assign new_sample_ready = ready_q;

endmodule

// File: tb/tb_harmonic_note_player.sv
// Randomised scoreboard bench for harmonic_note_player with a behavioural note/mix model.
module tb_harmonic_note_player;

   logic               clk = 1'b0;
   logic               reset;
   logic               play_enable;
   logic [5:0]         note_to_load;
   logic [5:0]         duration_to_load;
   logic               load_new_note;
   logic [11:0]        weights;
   logic               beat;
   logic               generate_next_sample;
   logic               done_with_note;
   logic               busy;
   logic signed [15:0] sample_out;
   logic               new_sample_ready;

   harmonic_note_player #(
      .NUM_HARMONICS (3),
      .NOTE_W        (6),
      .DUR_W         (6),
      .SAMPLE_W      (16)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .play_enable          (play_enable),
      .note_to_load         (note_to_load),
      .duration_to_load     (duration_to_load),
      .load_new_note        (load_new_note),
      .weights              (weights),
      .beat                 (beat),
      .generate_next_sample (generate_next_sample),
      .done_with_note       (done_with_note),
      .busy                 (busy),
      .sample_out           (sample_out),
      .new_sample_ready     (new_sample_ready)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int sample_idx = 0;

   // Reference model state: note playing, beats left, gains and harmonic phases.
   int m_busy = 0;
   int m_remaining = 0;
   int m_note = 0;
   int m_w[3] = '{0, 0, 0};
   int m_phase[3] = '{0, 0, 0};
   int m_done_total = 0;
   int got_done = 0;
   int exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int step_of(input int note);
      return (note * 5461) % 1048576;
   endfunction

   // Parabolic half-wave: x in 0..511 across each half period, peak clipped to 32767.
   function automatic int wave_ref(input int ph);
      int pos;
      int x;
      int m;
      pos = ph / 1024;
      x   = pos % 512;
      m   = (x * (512 - x)) / 2;
      if (m > 32767) m = 32767;
      return (pos >= 512) ? -m : m;
   endfunction

   function automatic int mix_next();
      int s;
      s = 0;
      for (int k = 0; k < 3; k++) begin
         m_phase[k] = (m_phase[k] + (step_of(m_note) * (k + 1)) % 1048576) % 1048576;
         s += (wave_ref(m_phase[k]) * m_w[k]) >>> 4;
      end
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (4) cyc();
   endtask

   task automatic op_load(input int note, input int dur, input int wp, input bit with_beat);
      drain();
      note_to_load     = 6'(note);
      duration_to_load = 6'(dur);
      weights          = 12'(wp);
      load_new_note    = 1'b1;
      beat             = with_beat;
      cyc();
      load_new_note = 1'b0;
      beat          = 1'b0;
      m_busy      = 1;
      m_remaining = (dur == 0) ? 1 : dur;
      m_note      = note;
      for (int k = 0; k < 3; k++) m_w[k] = (wp >> (4 * k)) & 15;
      $display("[TB] load note=%0d dur=%0d w=%03h beat=%0d", note, dur, wp, with_beat);
      check("busy_after_load", int'(busy), 1);
      check("done_after_load", int'(done_with_note), 0);
      cyc();
      cyc();
   endtask

   task automatic op_beat();
      int exp_done;
      exp_done = 0;
      beat = 1'b1;
      cyc();
      beat = 1'b0;
      if (play_enable && m_busy == 1) begin
         m_remaining--;
         if (m_remaining == 0) begin
            m_busy   = 0;
            exp_done = 1;
            m_done_total++;
         end
      end
      $display("[TB] beat en=%0d done=%0d busy=%0d", play_enable, done_with_note, busy);
      check("beat_done", int'(done_with_note), exp_done);
      check("beat_busy", int'(busy), m_busy);
   endtask

   task automatic op_request();
      int e;
      generate_next_sample = 1'b1;
      if (play_enable) begin
         if (m_busy == 1) begin
            e = mix_next();
            if (m_note == 0) e = 0;
         end else begin
            e = 0;
         end
         exp_q.push_back(e);
      end
      cyc();
      generate_next_sample = 1'b0;
   endtask

   task automatic op_reset();
      drain();
      reset            = 1'b1;
      load_new_note    = 1'b1;
      note_to_load     = 6'd5;
      duration_to_load = 6'd3;
      cyc();
      reset         = 1'b0;
      load_new_note = 1'b0;
      m_busy = 0;
      m_note = 0;
      for (int k = 0; k < 3; k++) begin
         m_phase[k] = 0;
         m_w[k]     = 0;
      end
      $display("[TB] reset");
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done_with_note), 0);
      check("rst_ready", int'(new_sample_ready), 0);
      check("rst_sample", int'(sample_out), 0);
      cyc();
      check("rst_busy_hold", int'(busy), 0);
      check("rst_done_hold", int'(done_with_note), 0);
   endtask

   // Monitor: every ready pulse is matched against the oldest expected sample.
   initial begin : monitor
      int e;
      forever begin
         @(negedge clk);
         if (done_with_note) got_done++;
         if (new_sample_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_ready: got sample %0d, expected no ready pulse", sample_out);
            end else begin
               e = exp_q.pop_front();
               sample_idx++;
               $display("[TB] sample %0d got=%0d exp=%0d", sample_idx, sample_out, e);
               check("sample", int'(sample_out), e);
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      reset                = 1'b1;
      play_enable          = 1'b0;
      note_to_load         = '0;
      duration_to_load     = '0;
      load_new_note        = 1'b0;
      weights              = '0;
      beat                 = 1'b0;
      generate_next_sample = 1'b0;
      repeat (3) cyc();
      reset = 1'b0;
      check("init_busy", int'(busy), 0);
      check("init_done", int'(done_with_note), 0);
      check("init_sample", int'(sample_out), 0);
      check("init_ready", int'(new_sample_ready), 0);

      // Duration 3 lasts exactly three beats.
      play_enable = 1'b1;
      op_load(10, 3, 12'h888, 1'b0);
      repeat (3) op_beat();
      cyc();
      check("done_single_pulse", int'(done_with_note), 0);

      // Reload coincident with a beat restarts the count.
      op_load(10, 5, 12'h888, 1'b0);
      repeat (2) op_beat();
      op_load(10, 2, 12'h888, 1'b1);
      repeat (2) op_beat();

      // Only the fundamental weighted.
      op_reset();
      op_load(7, 10, 12'h00F, 1'b0);
      repeat (6) op_request();

      // All weights at maximum near the crest must clip positive.
      op_reset();
      op_load(24, 10, 12'hFFF, 1'b0);
      op_request();
      drain();
      check("saturate_pos", int'(sample_out), 32767);

      // Pause across four beats and two requests, then finish the note.
      op_load(12, 4, 12'h5A3, 1'b0);
      op_beat();
      op_request();
      drain();
      play_enable = 1'b0;
      repeat (4) op_beat();
      repeat (2) op_request();
      play_enable = 1'b1;
      repeat (3) op_beat();
      op_request();

      // Reset mid-note, then a rest note and an idle request.
      op_load(30, 6, 12'h777, 1'b0);
      op_beat();
      op_reset();
      op_load(0, 2, 12'hFFF, 1'b0);
      repeat (2) op_request();
      repeat (2) op_beat();
      op_request();

      for (int n = 0; n < 400; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 8) begin
            op_load(int'($urandom_range(0, 63)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 4095)), ($urandom_range(0, 3) == 0));
         end else if (r < 35) begin
            op_beat();
         end else if (r < 85) begin
            op_request();
         end else if (r < 95) begin
            play_enable = ~play_enable;
            cyc();
         end else if (r < 97) begin
            op_reset();
         end else begin
            cyc();
         end
      end

      repeat (6) cyc();
      check("queue_empty", exp_q.size(), 0);
      check("done_count", got_done, m_done_total);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
